// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath widths, reset PC, opcode map and
// the fetch-stage payload and state types.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Major opcodes (inst[6:0]), shared with the control unit
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] bits;
   } fetch_entry_t;

   typedef enum logic {
      FETCH = 1'b0,
      DROP  = 1'b1
   } fetch_state_e;

   // Sequential fetch address; wraps 32'hFFFF_FFFC -> 0 naturally
   function automatic logic [XLEN-1:0] next_fetch_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer of {pc, instruction} entries with synchronous flush.
// Head entry is presented combinationally.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  fetch_entry_t wdata_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output fetch_entry_t rdata_o,
   output logic [CW-1:0] count_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Flush dominates any push or pop in the same cycle
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, runs the single-outstanding imem
// handshake, buffers words and hands {pc, inst} pairs to decode.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [ILEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [ILEN-1:0] inst_bits,
   output logic [XLEN-1:0] inst_pc,
   output logic            misalign
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            misalign_q, misalign_d;

   logic            req;
   logic            push;
   logic            pop;
   logic            flush;
   fetch_entry_t    head;
   logic [CW-1:0]   fifo_count;
   logic            fifo_empty;
   logic            fifo_full;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i ('{pc: fetch_pc_q, bits: imem_rdata}),
      .pop_i   (pop),
      .flush_i (flush),
      .rdata_o (head),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Next-state, PC and handshake control
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      misalign_d = 1'b0;
      req        = 1'b0;
      push       = 1'b0;
      flush      = 1'b0;

      unique case (state_q)
         FETCH: begin
            req = ~rst & (fifo_count < CW'(DEPTH));
            if (redirect_valid) begin
               if (req & ~imem_ack) state_d = DROP;
            end else if (req & imem_ack & ~fifo_full) begin
               push       = 1'b1;
               fetch_pc_d = next_fetch_pc(fetch_pc_q);
            end
         end
         DROP: begin
            if (imem_ack) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase

      pop = ~fifo_empty & inst_ready & ~redirect_valid;

      if (redirect_valid) begin
         flush      = 1'b1;
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         misalign_d = |redirect_pc[1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_req   = req;
   assign imem_addr  = fetch_pc_q;
   assign inst_valid = ~fifo_empty;
   assign inst_bits  = head.bits;
   assign inst_pc    = head.pc;
   assign misalign   = misalign_q;

endmodule
